// File: rtl/prime_counter_pkg.sv
// Shared types and constants for the prime_counter sieve: widths, trial-divisor table, FSM states.
package prime_counter_pkg;

  localparam int unsigned NUM_W_DEFAULT = 10;
  localparam int unsigned CNT_W_DEFAULT = 8;

  // Primes up to 31 cover every composite up to 1023 (37*37 > 1023).
  localparam int unsigned NUM_TRIAL = 11;
  localparam logic [NUM_TRIAL-1:0][7:0] TRIAL_PRIMES = {
    8'd31, 8'd29, 8'd23, 8'd19, 8'd17, 8'd13, 8'd11, 8'd7, 8'd5, 8'd3, 8'd2
  };

  typedef enum logic {
    RUN  = 1'b0,
    DONE = 1'b1
  } state_t;

endpackage

// File: rtl/prime_check.sv
// Combinational divisibility test of a value against the fixed trial-prime table.
module prime_check
  import prime_counter_pkg::*;
#(
  parameter int unsigned NUM_W = NUM_W_DEFAULT
) (
  input  logic [NUM_W-1:0]     i_value,
  output logic [NUM_TRIAL-1:0] o_hits
);

  logic [31:0] w_value;
  assign w_value = 32'(i_value);

  for (genvar g = 0; g < NUM_TRIAL; g++) begin : g_trial
    localparam logic [31:0] Div = 32'(TRIAL_PRIMES[g]);
    // A divisor equal to the value itself is the value being prime, not a hit.
    assign o_hits[g] = ((w_value % Div) == 32'd0) && (w_value != Div);
  end

endmodule

// File: rtl/prime_counter.sv
// Sequential prime sieve: tests candidates 2..i_num_max, one every 4 clocks, and counts primes.
// Optional macro PRIMENUMS_DONE_EN adds a sticky o_done completion output.
module prime_counter
  import prime_counter_pkg::*;
#(
  parameter int unsigned NUM_W = NUM_W_DEFAULT,
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic             i_sys_clk,
  input  logic             i_reset,
  input  logic [NUM_W-1:0] i_num_max,
  output logic             o_prime,
  output logic [NUM_W-1:0] o_number_checked,
  output logic [CNT_W-1:0] o_number_of_primes_found
`ifdef PRIMENUMS_DONE_EN
  ,
  output logic             o_done
`endif
);

  state_t               r_state;
  logic [1:0]           r_phase;
  logic [NUM_W:0]       r_cand;
  logic [NUM_W-1:0]     r_test;
  logic [NUM_TRIAL-1:0] r_hits;
  logic                 r_is_prime;
  logic                 r_prime;
  logic [NUM_W-1:0]     r_number_checked;
  logic [CNT_W-1:0]     r_count;
`ifdef PRIMENUMS_DONE_EN
  logic                 r_done;
`endif

  logic [NUM_TRIAL-1:0] w_hits;
  logic [NUM_W-1:0]     w_cand_sat;
  logic                 w_past_max;
  logic                 w_count_full;

  prime_check #(
    .NUM_W (NUM_W)
  ) u_prime_check (
    .i_value (r_test),
    .o_hits  (w_hits)
  );

  // The candidate carries one extra bit so that stepping past the top value is visible.
  assign w_cand_sat   = r_cand[NUM_W] ? {NUM_W{1'b1}} : r_cand[NUM_W-1:0];
  assign w_past_max   = r_cand > {1'b0, i_num_max};
  assign w_count_full = &r_count;

  always_ff @(posedge i_sys_clk) begin
    if (i_reset) begin
      r_state          <= RUN;
      r_phase          <= 2'd0;
      r_cand           <= (NUM_W + 1)'(2);
      r_test           <= '0;
      r_hits           <= '0;
      r_is_prime       <= 1'b0;
      r_prime          <= 1'b0;
      r_number_checked <= '0;
      r_count          <= '0;
`ifdef PRIMENUMS_DONE_EN
      r_done           <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        RUN: begin
          r_phase <= r_phase + 2'd1;
          unique case (r_phase)
            2'd0: begin
              if (w_past_max) begin
                r_state          <= DONE;
                r_number_checked <= w_cand_sat;
                r_prime          <= 1'b0;
`ifdef PRIMENUMS_DONE_EN
                r_done           <= 1'b1;
`endif
              end else begin
                r_test <= r_cand[NUM_W-1:0];
              end
            end
            2'd1: begin
              r_hits <= w_hits;
            end
            2'd2: begin
              r_is_prime <= (r_test >= NUM_W'(2)) && (r_hits == '0);
            end
            2'd3: begin
              r_number_checked <= r_test;
              r_prime          <= r_is_prime;
              if (r_is_prime && !w_count_full) begin
                r_count <= r_count + CNT_W'(1);
              end
              r_cand <= r_cand + (NUM_W + 1)'(1);
            end
            default: ;
          endcase
        end
        DONE: ;
        default: r_state <= DONE;
      endcase
    end
  end

  assign o_prime                  = r_prime;
  assign o_number_checked         = r_number_checked;
  assign o_number_of_primes_found = r_count;
`ifdef PRIMENUMS_DONE_EN
  assign o_done                   = r_done;
`endif

endmodule

// File: tb/tb_prime_counter.sv
// Self-checking bench for prime_counter: directed tables plus reset / NumMax-change sequences.
module tb_prime_counter;

  localparam int unsigned NW = 10;
  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [NW-1:0] num_max;
  logic          prime;
  logic [NW-1:0] nc;
  logic [CW-1:0] cnt;
`ifdef PRIMENUMS_DONE_EN
  logic          done;
`endif

  int checks   = 0;
  int failures = 0;

  bit golden   [0:1025];
  bit obs_prime[0:1025];

  typedef struct {
    int  nc;
    bit  pr;
    int  cnt;
  } pub_vec_t;

  typedef struct {
    int nmax;
    int nc;
    int cnt;
  } end_vec_t;

  always #5 clk = ~clk;

  prime_counter dut (
    .i_sys_clk                (clk),
    .i_reset                  (rst),
    .i_num_max                (num_max),
    .o_prime                  (prime),
    .o_number_checked         (nc),
`ifdef PRIMENUMS_DONE_EN
    .o_done                   (done),
`endif
    .o_number_of_primes_found (cnt)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Called at a negedge; asserts reset across one rising edge and checks the cleared outputs.
  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_nc", int'(nc), 0);
    check("rst_prime", int'(prime), 0);
    check("rst_cnt", int'(cnt), 0);
`ifdef PRIMENUMS_DONE_EN
    check("rst_done", int'(done), 0);
`endif
    rst = 1'b0;
  endtask

  // Tracks one run from reset release. stop_at>0 returns right after that value is published;
  // lower_at>0 drops NumMax to lower_to right after that value is published.
  task automatic run(input int nmax, input int stop_at, input int lower_at, input int lower_to,
                     output int fin_nc, output int fin_cnt);
    int lim     = nmax;
    int exp_cnt = 0;
    int prev_nc = 0;
    int prev_pr = 0;
    fin_nc  = -1;
    fin_cnt = -1;
    num_max = NW'(nmax);
    for (int v = 2; v <= 1025; v++) begin
      for (int k = 1; k <= 4; k++) begin
        @(posedge clk);
        @(negedge clk);
        if (v > lim) begin
          check("done_nc", int'(nc), (v > 1023) ? 1023 : v);
          check("done_prime", int'(prime), 0);
          check("done_cnt", int'(cnt), exp_cnt);
`ifdef PRIMENUMS_DONE_EN
          check("done_flag", int'(done), 1);
`endif
          num_max = '1;
          repeat (12) @(posedge clk);
          @(negedge clk);
          check("hold_nc", int'(nc), (v > 1023) ? 1023 : v);
          check("hold_cnt", int'(cnt), exp_cnt);
          check("hold_prime", int'(prime), 0);
          fin_nc  = int'(nc);
          fin_cnt = int'(cnt);
          return;
        end
        if (k < 4) begin
          check("cadence_nc", int'(nc), prev_nc);
          check("cadence_prime", int'(prime), prev_pr);
        end else begin
          exp_cnt += int'(golden[v]);
          obs_prime[v] = prime;
          check("pub_nc", int'(nc), v);
          check("pub_prime", int'(prime), int'(golden[v]));
          check("pub_cnt", int'(cnt), exp_cnt);
`ifdef PRIMENUMS_DONE_EN
          check("pub_done", int'(done), 0);
`endif
          prev_nc = v;
          prev_pr = int'(golden[v]);
          if (v == stop_at) begin
            fin_nc  = int'(nc);
            fin_cnt = int'(cnt);
            return;
          end
          if (v == lower_at) begin
            num_max = NW'(lower_to);
            lim     = lower_to;
          end
        end
      end
    end
    checks++;
    failures++;
    $display("FAIL run_timeout actual=no_done required=done_by_1024");
  endtask

  pub_vec_t pub_tab[10];
  end_vec_t end_tab[6];

  initial begin
    int fnc;
    int fcnt;

    // Reference primality by full sieve.
    for (int i = 0; i <= 1025; i++) golden[i] = (i >= 2);
    for (int i = 2; i * i <= 1025; i++)
      if (golden[i]) for (int j = i * i; j <= 1025; j += i) golden[j] = 1'b0;

    pub_tab = '{
      '{2, 1'b1, 1}, '{3, 1'b1, 2}, '{4, 1'b0, 2}, '{5, 1'b1, 3}, '{6, 1'b0, 3},
      '{7, 1'b1, 4}, '{8, 1'b0, 4}, '{9, 1'b0, 4}, '{10, 1'b0, 4}, '{11, 1'b0, 4}
    };
    end_tab = '{
      '{0, 2, 0}, '{1, 2, 0}, '{2, 3, 1}, '{3, 4, 2}, '{1000, 1001, 168}, '{1023, 1023, 172}
    };

    num_max = '0;
    @(negedge clk);

    // NumMax=10, hand-computed publish table; last row is the DONE state.
    num_max = NW'(10);
    pulse_reset();
    for (int i = 0; i < 10; i++) begin
      repeat (4) @(posedge clk);
      @(negedge clk);
      check($sformatf("tab10_nc[%0d]", i), int'(nc), pub_tab[i].nc);
      check($sformatf("tab10_prime[%0d]", i), int'(prime), int'(pub_tab[i].pr));
      check($sformatf("tab10_cnt[%0d]", i), int'(cnt), pub_tab[i].cnt);
    end

    // Final state for a range of NumMax values, with full cadence/publish tracking.
    for (int i = 0; i < 6; i++) begin
      num_max = NW'(end_tab[i].nmax);
      pulse_reset();
      run(end_tab[i].nmax, -1, -1, 0, fnc, fcnt);
      check($sformatf("end_nc[nmax=%0d]", end_tab[i].nmax), fnc, end_tab[i].nc);
      check($sformatf("end_cnt[nmax=%0d]", end_tab[i].nmax), fcnt, end_tab[i].cnt);
    end
    check("p961", int'(obs_prime[961]), 0);
    check("p997", int'(obs_prime[997]), 1);
    check("p1021", int'(obs_prime[1021]), 1);

    // Reset mid-run once 50 has been published, then a full restart.
    num_max = NW'(1000);
    pulse_reset();
    run(1000, 50, -1, 0, fnc, fcnt);
    check("mid_nc", fnc, 50);
    check("mid_cnt", fcnt, 15);
    pulse_reset();
    run(1000, -1, -1, 0, fnc, fcnt);
    check("restart_nc", fnc, 1001);
    check("restart_cnt", fcnt, 168);

    // Lower NumMax to 20 after 30 is published: DONE on the next phase 0.
    num_max = NW'(1000);
    pulse_reset();
    run(1000, -1, 30, 20, fnc, fcnt);
    check("lower_nc", fnc, 31);
    check("lower_cnt", fcnt, 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
